// File: rtl/button_reader.sv
// Debounced pushbutton/switch reader: two-flop synchroniser, per-channel stability
// counter, and registered press / release / long-press strobes.
module button_reader #(
    parameter int WIDTH       = 6,
    parameter int DB_CYCLES   = 1000000,
    parameter int LONG_CYCLES = 50000000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             clk50,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_pulse,
    output logic             any_pressed
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int HW  = $clog2(LONG_CYCLES + 1);

    localparam logic [WIDTH-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [DBW-1:0]   DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_MAX   = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(LONG_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] pressed_q, pressed_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] long_q, long_d;
    logic             any_q, any_d;

    always_comb begin
        s1_d  = btn_in;
        s2_d  = s1_q;
        any_d = |pressed_q;
    end

    // Normalised so that 1 always means "pressed" regardless of board wiring.
    assign raw = s2_q ^ IDLE_LEVEL;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [DBW-1:0] db_cnt_q, db_cnt_d;
            logic [HW-1:0]  hold_q, hold_d;
            logic           ch_pressed_d, ch_press_d, ch_release_d, ch_long_d;

            always_comb begin
                db_cnt_d     = db_cnt_q;
                ch_pressed_d = pressed_q[gi];
                ch_press_d   = 1'b0;
                ch_release_d = 1'b0;
                if (raw[gi] == pressed_q[gi]) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    db_cnt_d     = '0;
                    ch_pressed_d = ~pressed_q[gi];
                    ch_press_d   = raw[gi];
                    ch_release_d = ~raw[gi];
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end

                // Saturating hold count; a release on the final edge suppresses the strobe.
                hold_d    = hold_q;
                ch_long_d = 1'b0;
                if (!pressed_q[gi]) begin
                    hold_d = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d    = hold_q + HW'(1);
                    ch_long_d = (hold_q == HOLD_LAST) && ch_pressed_d;
                end
            end

            always_ff @(posedge clk50) begin
                if (rst) begin
                    db_cnt_q <= '0;
                    hold_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_d;
                    hold_q   <= hold_d;
                end
            end

            assign pressed_d[gi] = ch_pressed_d;
            assign press_d[gi]   = ch_press_d;
            assign release_d[gi] = ch_release_d;
            assign long_d[gi]    = ch_long_d;
        end
    endgenerate

    always_ff @(posedge clk50) begin
        if (rst) begin
            s1_q      <= IDLE_LEVEL;
            s2_q      <= IDLE_LEVEL;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            any_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            any_q     <= any_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign any_pressed   = any_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: expected strobes are queued with their
// predicted edge number when stimulus is driven and matched as the DUT emits them.
module tb_button_reader;

    logic       clk50 = 1'b0;
    logic       rst;
    logic [5:0] btn_in;
    logic [5:0] pressed, press_pulse, release_pulse, long_pulse;
    logic       any_pressed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [5:0] press;
        logic [5:0] rel;
        logic [5:0] lng;
    } exp_t;

    exp_t exp_q[$];

    button_reader #(
        .WIDTH(6), .DB_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1)
    ) dut (
        .clk50(clk50), .rst(rst), .btn_in(btn_in),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .any_pressed(any_pressed)
    );

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at edge %0d", tag, got, exp, cyc);
        end
    endtask

    // Insert keeping the queue ordered by edge; same-edge events merge.
    function automatic void add_exp(input int c, input logic [5:0] p, input logic [5:0] r,
                                    input logic [5:0] l);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == c) begin
                exp_q[i].press = exp_q[i].press | p;
                exp_q[i].rel   = exp_q[i].rel | r;
                exp_q[i].lng   = exp_q[i].lng | l;
                return;
            end
            if (exp_q[i].cyc > c) begin
                exp_q.insert(i, e);
                return;
            end
        end
        exp_q.push_back(e);
    endfunction

    // Called on a falling edge; returns the rising edge that samples the new level.
    task automatic drive(input logic [5:0] v, output int k);
        btn_in = v;
        k = cyc + 1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk50);
    endtask

    always @(negedge clk50) begin
        if (cyc > 0) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_evt", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                $display("evt edge=%0d press=%h release=%h long=%h", cyc,
                         press_pulse, release_pulse, long_pulse);
                check("press_pulse",   32'(press_pulse),   32'(exp_q[0].press));
                check("release_pulse", 32'(release_pulse), 32'(exp_q[0].rel));
                check("long_pulse",    32'(long_pulse),    32'(exp_q[0].lng));
                void'(exp_q.pop_front());
            end else if ((press_pulse | release_pulse | long_pulse) != 6'h00) begin
                check("spurious", {14'd0, press_pulse, release_pulse, long_pulse}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished at edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k, k2, p, r;
        rst    = 1'b1;
        btn_in = 6'h3F;

        // Reset and idle with nothing pressed
        repeat (3) @(negedge clk50);
        check("rst_pressed", 32'(pressed), 32'h0);
        check("rst_any", 32'(any_pressed), 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk50);
        check("idle_pressed", 32'(pressed), 32'h0);
        check("idle_any", 32'(any_pressed), 32'h0);

        // Clean press, long press, hold, release
        drive(6'h3E, k);
        add_exp(k + 5, 6'h01, 6'h00, 6'h00);
        add_exp(k + 15, 6'h00, 6'h00, 6'h01);
        wait_until(k + 5);
        check("press_level", 32'(pressed), 32'h01);
        check("any_lag", 32'(any_pressed), 32'h0);
        wait_until(k + 6);
        check("any_set", 32'(any_pressed), 32'h1);
        wait_until(k + 45);
        drive(6'h3F, k2);
        add_exp(k2 + 5, 6'h00, 6'h01, 6'h00);
        wait_until(k2 + 5);
        check("release_level", 32'(pressed), 32'h00);
        wait_until(k2 + 6);
        check("any_clear", 32'(any_pressed), 32'h0);

        // Short press released at hold count 9: no long strobe
        drive(6'h3E, k);
        p = k + 5;
        add_exp(p, 6'h01, 6'h00, 6'h00);
        wait_until(k + 8);
        drive(6'h3F, k2);
        add_exp(k2 + 5, 6'h00, 6'h01, 6'h00);
        wait_until(p + 15);
        check("short_pressed", 32'(pressed), 32'h00);

        // Bounce: low 3 / high 1, five times
        for (int i = 0; i < 5; i++) begin
            drive(6'h3E, k);
            repeat (3) @(negedge clk50);
            drive(6'h3F, k);
            @(negedge clk50);
        end
        repeat (10) @(negedge clk50);
        check("bounce_pressed", 32'(pressed), 32'h00);
        drive(6'h3E, k);
        add_exp(k + 5, 6'h01, 6'h00, 6'h00);
        repeat (4) @(negedge clk50);
        drive(6'h3F, k2);
        add_exp(k + 9, 6'h00, 6'h01, 6'h00);
        wait_until(k + 5);
        check("stable4_pressed", 32'(pressed), 32'h01);
        wait_until(k + 9);
        check("stable4_release", 32'(pressed), 32'h00);
        wait_until(k + 20);

        // Simultaneous channels 2 and 5
        drive(6'h1B, k);
        add_exp(k + 5, 6'h24, 6'h00, 6'h00);
        add_exp(k + 15, 6'h00, 6'h00, 6'h24);
        wait_until(k + 5);
        check("simul_pressed", 32'(pressed), 32'h24);
        wait_until(k + 20);
        drive(6'h1F, k2);
        add_exp(k2 + 5, 6'h00, 6'h04, 6'h00);
        wait_until(k2 + 5);
        check("partial_pressed", 32'(pressed), 32'h20);
        wait_until(k2 + 6);
        check("partial_any", 32'(any_pressed), 32'h1);
        drive(6'h3F, k2);
        add_exp(k2 + 5, 6'h00, 6'h20, 6'h00);
        wait_until(k2 + 10);

        // Reset mid-hold on channel 1, button kept held
        drive(6'h3D, k);
        p = k + 5;
        add_exp(p, 6'h02, 6'h00, 6'h00);
        wait_until(p + 6);
        rst = 1'b1;
        @(negedge clk50);
        check("midrst_pressed", 32'(pressed), 32'h00);
        check("midrst_any", 32'(any_pressed), 32'h0);
        rst = 1'b0;
        r = cyc + 1;
        add_exp(r + 5, 6'h02, 6'h00, 6'h00);
        add_exp(r + 15, 6'h00, 6'h00, 6'h02);
        wait_until(r + 5);
        check("reaccept_pressed", 32'(pressed), 32'h02);
        wait_until(r + 16);
        drive(6'h3F, k2);
        add_exp(k2 + 5, 6'h00, 6'h02, 6'h00);
        wait_until(k2 + 8);
        check("final_pressed", 32'(pressed), 32'h00);

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
